// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its debounce FSM.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_HELD,
    S_DEB_RELEASE
  } state_t;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEYS = ROWS * COLS;

  // Key meanings as interpreted by the downstream decoder (bit = row*4 + col)
  localparam logic [15:0] KEY_ENTER  = 16'h0001;
  localparam logic [15:0] KEY_CLEAR  = 16'h0100;
  localparam logic [15:0] KEY_CANCEL = 16'h1000;
  localparam logic [15:0] KEY_D0     = 16'h0008;
  localparam logic [15:0] KEY_D1     = 16'h0080;
  localparam logic [15:0] KEY_D2     = 16'h0040;
  localparam logic [15:0] KEY_D3     = 16'h0020;
  localparam logic [15:0] KEY_D4     = 16'h0800;
  localparam logic [15:0] KEY_D5     = 16'h0400;
  localparam logic [15:0] KEY_D6     = 16'h0200;
  localparam logic [15:0] KEY_D7     = 16'h8000;
  localparam logic [15:0] KEY_D8     = 16'h4000;
  localparam logic [15:0] KEY_D9     = 16'h2000;

  function automatic logic [3:0] onehot_to_index(input logic [15:0] code);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (code[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_row_scan.sv
// Row driver and column sampler: walks one active-low row per slot and
// assembles a full 16-bit key snapshot once per frame.
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [COLS-1:0] i_col_n,
  output logic [ROWS-1:0] o_row_n,
  output logic [KEYS-1:0] o_frame,
  output logic            o_frame_done
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  logic [COLS-1:0]   r_col_meta;
  logic [COLS-1:0]   r_col_s;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [1:0]        r_row_idx;
  logic [KEYS-1:0]   r_snapshot;

  logic              w_slot_last;
  logic [KEYS-1:0]   w_snap_next;

  assign w_slot_last = (r_slot_cnt == SLOT_LAST);

  // Snapshot including the row being sampled this cycle, so the frame seen at
  // frame_done already carries the row-3 columns.
  always_comb begin
    w_snap_next = r_snapshot;
    if (w_slot_last) begin
      for (int c = 0; c < COLS; c++) begin
        w_snap_next[{r_row_idx, 2'(c)}] = ~r_col_s[c];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col_meta <= '1;
      r_col_s    <= '1;
      r_slot_cnt <= '0;
      r_row_idx  <= '0;
      r_snapshot <= '0;
    end else begin
      r_col_meta <= i_col_n;
      r_col_s    <= r_col_meta;
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        r_row_idx  <= r_row_idx + 2'd1;
        r_snapshot <= w_snap_next;
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
      end
    end
  end

  assign o_row_n      = ~(4'b0001 << r_row_idx);
  assign o_frame      = w_snap_next;
  assign o_frame_done = w_slot_last && (r_row_idx == 2'd3);

endmodule

// File: rtl/keypad_scan_encoder.sv
// Keypad scanner top: debounces whole-frame snapshots into a one-hot key code.
//  state         | meaning
//  S_IDLE        | no key confirmed, waiting for a single-key frame
//  S_DEB_PRESS   | candidate key seen, counting agreeing frames
//  S_HELD        | key confirmed, onehot/key_code driven
//  S_DEB_RELEASE | candidate missing, counting frames before release
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_col_n,
  output logic [3:0]  o_row_n,
  output logic [15:0] o_onehot,
  output logic        o_key_valid,
  output logic [3:0]  o_key_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_FRAMES);

  logic [15:0]      w_frame;
  logic             w_frame_done;
  logic             w_zero;
  logic             w_single;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_deb_hit;

  state_t           r_state;
  logic [15:0]      r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_onehot;
  logic [3:0]       r_key_code;
  logic             r_key_valid;

  keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_row_scan (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_col_n     (i_col_n),
    .o_row_n     (o_row_n),
    .o_frame     (w_frame),
    .o_frame_done(w_frame_done)
  );

  assign w_zero    = (w_frame == 16'd0);
  assign w_single  = !w_zero && ((w_frame & (w_frame - 16'd1)) == 16'd0);
  assign w_match   = (w_frame == r_cand);
  assign w_cnt_inc = (r_cnt == DEB_C) ? r_cnt : r_cnt + 1'b1;
  assign w_deb_hit = (w_cnt_inc == DEB_C);

  // Multi-key frames fall through untouched: they never advance or reset state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_onehot    <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_frame_done && (w_zero || w_single)) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand <= w_frame;
              r_cnt  <= CNT_W'(1);
              if (DEB_C == CNT_W'(1)) begin
                r_onehot    <= w_frame;
                r_key_code  <= onehot_to_index(w_frame);
                r_key_valid <= 1'b1;
                r_state     <= S_HELD;
              end else begin
                r_state <= S_DEB_PRESS;
              end
            end
          end
          S_DEB_PRESS: begin
            if (w_zero) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else if (w_match) begin
              r_cnt <= w_cnt_inc;
              if (w_deb_hit) begin
                r_onehot    <= r_cand;
                r_key_code  <= onehot_to_index(r_cand);
                r_key_valid <= 1'b1;
                r_state     <= S_HELD;
              end
            end else begin
              r_cand <= w_frame;
              r_cnt  <= CNT_W'(1);
            end
          end
          S_HELD: begin
            if (!w_match) begin
              r_cnt <= CNT_W'(1);
              if (DEB_C == CNT_W'(1)) begin
                r_onehot   <= '0;
                r_key_code <= '0;
                r_state    <= S_IDLE;
              end else begin
                r_state <= S_DEB_RELEASE;
              end
            end
          end
          S_DEB_RELEASE: begin
            if (w_match) begin
              r_state <= S_HELD;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_deb_hit) begin
                r_onehot   <= '0;
                r_key_code <= '0;
                r_state    <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_onehot    = r_onehot;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;

endmodule
